// File: rtl/fp_div_iter.sv
// rtl/fp_div_iter.sv - iterative radix-2 restoring IEEE-754 divider
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   act       start strobe, sampled only while idle
//   in1, in2  dividend / divisor, captured on act
//   round_m   rounding mode (`RNe/`RZ/`RU/`RD/`RNa), unknown codes round to zero
//   out       quotient, held until the next done
//   busy      high whenever an operation is in flight
//   done      one-cycle pulse, out and flags valid
//   ov, un, inv, div_zero, inexact  exception flags, held until the next done

`ifndef RNe
`define RNe 3'b000
`endif
`ifndef RZ
`define RZ  3'b001
`endif
`ifndef RD
`define RD  3'b010
`endif
`ifndef RU
`define RU  3'b011
`endif
`ifndef RNa
`define RNa 3'b100
`endif

module fp_div_iter #(
  parameter int EW = 8,
  parameter int MW = 23,
  localparam int W = EW + MW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         div_zero,
  output logic         inexact
);

  localparam int            CW    = $clog2(MW + 3);
  localparam logic [CW-1:0] LAST  = CW'(MW + 2);
  localparam logic [EW-1:0] EMAX  = '1;
  localparam logic [EW+1:0] BIAS  = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic [W-1:0]  QNAN  = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
  localparam logic [W-2:0]  INF_M = {EMAX, {MW{1'b0}}};
  localparam logic [W-2:0]  MAXF  = {{(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};

  typedef enum logic [2:0] {IDLE, CLASS, DIV, RND, OUT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [2:0]    rm_q;
  logic [EW+1:0] exp_q;
  logic [MW+1:0] rem_q;
  logic [MW:0]   dvs_q;
  logic [MW+2:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  res_q;
  logic [4:0]    flg_q;

  // Operand decode; subnormals are treated as zero.
  logic          s1, s2, sgn;
  logic [EW-1:0] e1, e2;
  logic [MW-1:0] f1, f2;
  logic          zero1, zero2, inf1, inf2, nan1, nan2, snan1, snan2;

  assign {s1, e1, f1} = a_q;
  assign {s2, e2, f2} = b_q;
  assign sgn   = s1 ^ s2;
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);
  assign inf1  = (e1 == EMAX) && (f1 == '0);
  assign inf2  = (e2 == EMAX) && (f2 == '0);
  assign nan1  = (e1 == EMAX) && (f1 != '0);
  assign nan2  = (e2 == EMAX) && (f2 != '0);
  assign snan1 = nan1 && !f1[MW-1];
  assign snan2 = nan2 && !f2[MW-1];

  logic         is_spec;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_flg;

  always_comb begin
    is_spec  = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (nan1 || nan2) begin
      spec_res    = QNAN;
      spec_flg[2] = snan1 || snan2;
    end else if ((zero1 && zero2) || (inf1 && inf2)) begin
      spec_res    = QNAN;
      spec_flg[2] = 1'b1;
    end else if (zero2 && !inf1) begin
      spec_res    = {sgn, INF_M};
      spec_flg[1] = 1'b1;
    end else if (inf1) begin
      spec_res = {sgn, INF_M};
    end else if (zero1 || inf2) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      is_spec = 1'b0;
    end
  end

  // Pre-normalise the dividend so the quotient lands in [1,2).
  logic [MW:0]   m1, m2;
  logic          adj;
  logic [MW+1:0] rem_init;
  logic [EW+1:0] exp_init;

  assign m1       = {1'b1, f1};
  assign m2       = {1'b1, f2};
  assign adj      = (m1 < m2);
  assign rem_init = adj ? {m1, 1'b0} : {1'b0, m1};
  assign exp_init = {2'b00, e1} - {2'b00, e2} + BIAS - {{(EW+1){1'b0}}, adj};

  // One restoring step: the partial remainder always stays below the divisor,
  // so the shifted remainder fits in MW+2 bits.
  logic [MW+2:0] diff;
  logic          ge;
  logic [MW+1:0] rem_sel, rem_nxt;

  assign diff    = {1'b0, rem_q} - {2'b00, dvs_q};
  assign ge      = ~diff[MW+2];
  assign rem_sel = ge ? diff[MW+1:0] : rem_q;
  assign rem_nxt = rem_sel << 1;

  logic          grd, rbit, stk, inc, carry, uflow, oflow;
  logic [MW+1:0] sum;
  logic [MW-1:0] frac;
  logic [EW+1:0] exp_r;
  logic [W-1:0]  rnd_res;
  logic [4:0]    rnd_flg;

  always_comb begin
    grd  = quo_q[1];
    rbit = quo_q[0];
    stk  = |rem_q;
    case (rm_q)
      `RNe:    inc = grd && (rbit || stk || quo_q[2]);
      `RNa:    inc = grd;
      `RU:     inc = !sgn && (grd || rbit || stk);
      `RD:     inc = sgn && (grd || rbit || stk);
      default: inc = 1'b0;
    endcase
    sum   = {1'b0, quo_q[MW+2:2]} + {{(MW+1){1'b0}}, inc};
    carry = sum[MW+1];
    frac  = carry ? sum[MW:1] : sum[MW-1:0];
    exp_r = exp_q + {{(EW+1){1'b0}}, carry};
    // Underflow is judged on the unrounded exponent (negative or zero).
    uflow = exp_q[EW+1] || (exp_q == '0);
    oflow = !exp_r[EW+1] && (exp_r >= {2'b00, EMAX});
    rnd_res = {sgn, exp_r[EW-1:0], frac};
    rnd_flg = {3'b000, 1'b0, grd || rbit || stk};
    if (uflow) begin
      rnd_res = {sgn, {(W-1){1'b0}}};
      rnd_flg = 5'b01001;
    end else if (oflow) begin
      rnd_flg = 5'b10001;
      case (rm_q)
        `RNe, `RNa: rnd_res = {sgn, INF_M};
        `RU:        rnd_res = sgn ? {1'b1, MAXF} : {1'b0, INF_M};
        `RD:        rnd_res = sgn ? {1'b1, INF_M} : {1'b0, MAXF};
        default:    rnd_res = {sgn, MAXF};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (act) state_d = CLASS;
      CLASS:   state_d = is_spec ? OUT : DIV;
      DIV:     if (cnt_q == LAST) state_d = RND;
      RND:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      rm_q  <= '0;
      exp_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (act) begin
          a_q  <= in1;
          b_q  <= in2;
          rm_q <= round_m;
        end
        CLASS: begin
          exp_q <= exp_init;
          rem_q <= rem_init;
          dvs_q <= m2;
          quo_q <= '0;
          cnt_q <= '0;
          if (is_spec) begin
            res_q <= spec_res;
            flg_q <= spec_flg;
          end
        end
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[MW+1:0], ge};
          cnt_q <= cnt_q + 1'b1;
        end
        RND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flg;
        end
        default: ;
      endcase
    end
  end

  assign out  = res_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == OUT);
  assign {ov, un, inv, div_zero, inexact} = flg_q;

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised, iterative IEEE-754 floating-point divider for the simple FPU. It replaces the single-precision combinational-core divider with a radix-2 restoring iteration over one shared datapath, generic in exponent and fraction width. It adds an act/busy/done handshake, an explicit classification stage, and IEEE overflow results chosen by rounding mode. It sits beside fp_add/fp_mul under the FPU top-level op decoder.

## Interface
- EW, 8: exponent width; bias = 2^(EW-1)-1
- MW, 23: stored fraction width; word width W = EW+MW+1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- act  in  1  start strobe; sampled only in IDLE
- in1  in  W  dividend
- in2  in  W  divisor
- round_m  in  3  rounding mode, shared `RNe/`RZ/`RU/`RD/`RNa codes; unknown codes behave as RZ
- out  out  W  quotient; held until next done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; out and flags valid
- ov, un, inv, div_zero, inexact  out  1 each  exception flags; valid with done and held until next done

## Operation
- Reset: state IDLE. out, busy, done and all flags are 0. Any in-flight operation is discarded.
- IDLE -> CLASS on act. in1, in2 and round_m are captured; later changes to the inputs have no effect.
- CLASS: decode sign, exponent and fraction. Subnormal inputs are flushed to signed zero.
- Special results go CLASS -> OUT. Sign is s1^s2 wherever it applies.
  - Any NaN input -> canonical qNaN (0, all-ones exponent, fraction MSB 1). inv=1 if either input is an sNaN.
  - 0/0 or inf/inf -> qNaN, inv=1.
  - finite nonzero / 0 -> inf, div_zero=1.
  - inf/finite -> inf.
  - 0/finite or finite/inf -> zero.
- Normal path:
  - m1 = 1.f1, m2 = 1.f2. If m1 < m2, shift m1 left 1 and set adj=1; this gives a quotient in [1,2).
  - Exponent e = e1 - e2 + bias - adj, computed signed in EW+2 bits.
  - DIV runs MW+3 restoring iterations and produces MW+1 quotient bits, guard and round. sticky = (remainder != 0).
- RND stage:
  - Rounding by mode:
    - RNe: increment if g & (r|s|lsb).
    - RNa: increment if g.
    - RZ: truncate.
    - RU: increment if positive and (g|r|s).
    - RD: increment if negative and (g|r|s).
  - A mantissa carry-out increments e.
  - inexact = g|r|s.
- Overflow (e >= 2^EW-1): ov=1, inexact=1.
  - RNe/RNa -> inf.
  - RZ -> max finite.
  - RU -> +inf if positive, -max finite if negative.
  - RD -> -inf if negative, +max finite if positive.
- Underflow (e < 1 before rounding): result is signed zero, un=1, inexact=1. There is no subnormal output.
- OUT: register out and flags, raise done, return to IDLE on the next edge.

## Timing
- Edge 0 samples act in IDLE. busy is high after edge 0.
- Special case: state is OUT after edge 1, so done is high in that cycle.
- Normal case: DIV is entered at edge 1, iterates on edges 2..MW+4, then RND, then OUT.
  - done is high in the cycle after edge MW+5: edge 28 for single precision, edge 15 for EW=5/MW=10.
- Latency is fixed per path and independent of the data.
- busy falls on the same edge that done falls. A new act is accepted in the cycle after done, giving 1 idle cycle between operations.
- act while busy is ignored and is never queued.
- Reset asserted mid-operation (any state) forces all outputs to 0 immediately. An act after reset release starts cleanly.

## Test plan
- 0x40C00000 / 0x40000000, RNe -> out=0x40400000, all flags 0, done after edge 28, busy high on edges 1..28.
- 0x3F800000 / 0x40400000 -> RNe 0x3EAAAAAB, RZ 0x3EAAAAAA, RU 0x3EAAAAAB, RD 0x3EAAAAAA, inexact=1 in each mode.
- Specials, each done after edge 1:
  - 0x3F800000/0x00000000 -> 0x7F800000, div_zero=1.
  - 0x00000000/0x80000000 -> 0x7FC00000, inv=1.
  - 0x7F800001/0x3F800000 -> 0x7FC00000, inv=1.
  - 0xBF800000/0x7F800000 -> 0x80000000.
- Range limits:
  - 0x7F000000/0x3E800000: RNe -> 0x7F800000 with ov=1, inexact=1; RZ -> 0x7F7FFFFF.
  - 0x00800000/0x40000000 -> 0x00000000 with un=1, inexact=1.
- Control: act pulsed during DIV is ignored and the first result is unchanged. rst pulsed low mid-DIV -> out, busy and done are 0. A following 6/2 completes with 0x40400000.
- Parameters EW=5, MW=10: 0x4200/0x4000 -> 0x3E00 after edge 15; 0x3C00/0x0000 -> 0x7C00 with div_zero=1.
